// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - forwarding select and stall generation over DEPTH tracked write slots
module fwd_hazard_unit #(
    parameter int REG_W = 5,
    parameter int DEPTH = 3,
    parameter int NSRC  = 2,
    parameter int LAT_W = 2,
    parameter int SEL_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    hold,
    input  logic                    flush,
    input  logic                    issue_valid,
    input  logic                    issue_wr,
    input  logic [REG_W-1:0]        issue_dst,
    input  logic [LAT_W-1:0]        issue_lat,
    input  logic [NSRC*REG_W-1:0]   id_src,
    input  logic [NSRC-1:0]         id_src_used,
    input  logic                    id_jr,
    input  logic [REG_W-1:0]        id_jr_src,
    output logic                    stall,
    output logic [NSRC*SEL_W-1:0]   ex_fwd_sel,
    output logic [SEL_W-1:0]        jr_fwd_sel,
    output logic [15:0]             stall_cnt
);

    localparam int MAX_LAT = DEPTH - 1;

    logic             slot_valid [DEPTH];
    logic [REG_W-1:0] slot_dst   [DEPTH];
    logic [LAT_W-1:0] slot_cnt   [DEPTH];
    logic [REG_W-1:0] ex_src     [NSRC];
    logic [NSRC-1:0]  ex_used;

    logic             issue;
    logic [LAT_W-1:0] lat_clamped;
    logic             op_stall;
    logic             jr_stall;

    int               id_hit [NSRC];
    logic [LAT_W-1:0] id_cnt [NSRC];
    int               ex_hit [NSRC];
    int               jr_hit;
    logic [LAT_W-1:0] jr_cnt;

    assign issue = issue_valid & ~stall & ~flush;

    always_comb begin
        lat_clamped = issue_lat;
        if (issue_lat == '0)
            lat_clamped = LAT_W'(1);
        else if (int'(issue_lat) > MAX_LAT)
            lat_clamped = LAT_W'(MAX_LAT);
    end

    // Searches run oldest to youngest so the youngest hit overwrites. Entries
    // writing r0 are never made valid, so register 0 can never match.
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            id_hit[i] = -1;
            id_cnt[i] = '0;
            ex_hit[i] = -1;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (slot_valid[k] && slot_dst[k] == id_src[i*REG_W +: REG_W]) begin
                    id_hit[i] = k;
                    id_cnt[i] = slot_cnt[k];
                end
            end
            for (int k = DEPTH - 1; k >= 1; k--) begin
                if (slot_valid[k] && slot_dst[k] == ex_src[i])
                    ex_hit[i] = k;
            end
        end
        jr_hit = -1;
        jr_cnt = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (slot_valid[k] && slot_dst[k] == id_jr_src) begin
                jr_hit = k;
                jr_cnt = slot_cnt[k];
            end
        end
    end

    always_comb begin
        op_stall   = 1'b0;
        ex_fwd_sel = '0;
        for (int i = 0; i < NSRC; i++) begin
            // A hit in the last slot is always ready, so only earlier slots stall.
            if (id_src_used[i] && id_hit[i] >= 0 && id_hit[i] <= DEPTH - 2 &&
                id_cnt[i] > LAT_W'(1))
                op_stall = 1'b1;
            if (ex_used[i] && ex_hit[i] > 0)
                ex_fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(ex_hit[i]);
        end
        jr_stall   = 1'b0;
        jr_fwd_sel = '0;
        if (id_jr && jr_hit >= 0) begin
            if (jr_cnt != '0)
                jr_stall = 1'b1;
            else if (jr_hit > 0)
                jr_fwd_sel = SEL_W'(jr_hit);
        end
        stall = issue_valid & ~flush & (op_stall | jr_stall);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                slot_valid[k] <= 1'b0;
                slot_dst[k]   <= '0;
                slot_cnt[k]   <= '0;
            end
            for (int i = 0; i < NSRC; i++)
                ex_src[i] <= '0;
            ex_used   <= '0;
            stall_cnt <= '0;
        end else if (!hold) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                slot_valid[k] <= slot_valid[k-1];
                slot_dst[k]   <= slot_dst[k-1];
                slot_cnt[k]   <= (slot_cnt[k-1] == '0) ? '0 : slot_cnt[k-1] - LAT_W'(1);
            end
            slot_valid[0] <= issue & issue_wr & (issue_dst != '0);
            slot_dst[0]   <= issue ? issue_dst : '0;
            slot_cnt[0]   <= (issue & issue_wr) ? lat_clamped : '0;
            for (int i = 0; i < NSRC; i++)
                ex_src[i] <= id_src[i*REG_W +: REG_W];
            ex_used <= issue ? id_src_used : '0;
            if (stall && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard unit: the successor to the fixed EX/MEM/WB forwarding logic. It tracks every in-flight register write over a configurable number of post-ID pipeline slots, each write carrying a per-instruction result latency. From that state it produces forwarding selects for NSRC EX-stage operands and for one ID-stage jump-register operand, plus a stall request. It sits beside the ID/EX pipeline register and replaces the separate forward and load-use stall logic.

## Interface
- REG_W, 5, register address width
- DEPTH, 3, tracked slots after ID (slot 0 = EX, slot DEPTH-1 = last write-back slot); minimum 2
- NSRC, 2, source operands per instruction
- LAT_W, 2, width of latency field
- SEL_W, $clog2(DEPTH), select width (derived)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; clears all state
- hold  in  1  freezes all state (memory wait)
- flush  in  1  kills the ID instruction; a bubble enters slot 0
- issue_valid  in  1  a valid instruction is in ID
- issue_wr  in  1  ID instruction writes a register
- issue_dst  in  REG_W  ID destination register
- issue_lat  in  LAT_W  first slot whose pipeline register holds the result (ALU = 1, load = 2)
- id_src  in  NSRC*REG_W  ID source registers
- id_src_used  in  NSRC  per-source "is read" flag
- id_jr  in  1  ID instruction is jr/jalr
- id_jr_src  in  REG_W  jr target register
- stall  out  1  hold IF/ID; a bubble goes to EX
- ex_fwd_sel  out  NSRC*SEL_W  per EX operand: 0 = register file, k = slot k
- jr_fwd_sel  out  SEL_W  0 = register file, k = slot k
- stall_cnt  out  16  saturating count of stall cycles

## Operation
- Each slot k holds: valid, dst, cnt (LAT_W bits). Slot 0 also holds src[NSRC] and used[NSRC] of the instruction in EX.
- Issue condition: issue_valid & !stall & !flush. A slot entry is valid only if issue_wr = 1 and issue_dst != 0.
- issue_lat is clamped to the range 1..DEPTH-1 before it is loaded into cnt.
- Advance every cycle with hold = 0:
  - slot k+1 <= slot k
  - cnt decrements, saturating at 0
  - slot DEPTH-1 retires
  - slot 0 <= the issued instruction, or a bubble (valid = 0, used = 0)
- An entry is ready when cnt = 0. Register 0 never matches.
- Matching: in every search, the youngest (lowest k) valid entry with matching dst wins. Older entries are ignored even if they are ready.
- ex_fwd_sel[i]:
  - search slots 1..DEPTH-1 for slot-0 src[i] when used[i] = 1
  - output k on a match, else 0
  - a matching entry that is not ready cannot occur; the stall logic guarantees this
- Operand stall: a used id_src matches its youngest entry at slot k ≤ DEPTH-2 with cnt ≥ 2. A match only at DEPTH-1 never stalls.
- jr stall: id_jr = 1 and the youngest match for id_jr_src is at any slot with cnt != 0 (slot 0 always qualifies). Otherwise jr_fwd_sel = k of a ready match in slots 1..DEPTH-1, else 0.
- stall = issue_valid & !flush & (operand stall | jr stall).
- stall_cnt increments on each cycle with stall = 1 and hold = 0, and saturates at 0xFFFF.
- Simultaneous events:
  - flush with stall: flush wins, bubble, stall_cnt unchanged
  - hold with anything: no state change, outputs still computed combinationally

## Timing
- All outputs are combinational from registered state plus the ID inputs. There are no registered outputs.
- Reset values: all slots invalid, cnt = 0, used = 0, stall = 0, ex_fwd_sel = 0, jr_fwd_sel = 0, stall_cnt = 0.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.
- Latency:
  - an issued ALU producer (lat 1) is forwardable to the next instruction in the cycle after its issue
  - a load (lat 2) forces exactly one stall cycle on a dependent successor
  - a jr following an ALU producer stalls one cycle; a jr following a load stalls two cycles

## Test plan
- ALU then dependent ALU: issue add r3 (lat 1), next cycle issue a reader of r3 on src0 → stall = 0; following cycle ex_fwd_sel[0] = 1; one cycle later the reader is out of EX.
- Load-use: lw r5 (lat 2), then a reader of r5 → stall = 1 for exactly one cycle, stall_cnt = 1; the reader then sees ex_fwd_sel = 2 (DEPTH = 3).
- Youngest wins: r7 written by instructions in slots 1 and 2 → ex_fwd_sel = 1. Writers to r0 → ex_fwd_sel = 0 and no stall.
- jr after ALU: add r31 then jr r31 → stall for 1 cycle, then jr_fwd_sel = 1. jr after lw r31 → stall for 2 cycles, then jr_fwd_sel = 2.
- Flush and hold: flush together with a load-use stall → bubble in slot 0, stall = 0, stall_cnt unchanged. Hold for 3 cycles → selects unchanged, no advance.
- Reset mid-operation: pulse reset low with valid slots present → all outputs read 0 immediately, stall_cnt = 0; the next issue behaves as if from an empty pipeline.
